fuzz_vec_harness: RTL and testbench

Synthesizable stimulus/response harness for fuzzed combinational or pipelined DUTs, replacing hand-written vector lists and per-cycle output dumps. On `start` it drives NUM_VEC generated input vectors into the DUT, one per clock. It folds every DUT response into a 32-bit signature (MISR) and reports `done` and pass/fail against a golden value. It sits between the bench (or an on-chip controller) and the DUT's flattened input/output buses.

---
 rtl/fuzz_vec_harness.sv | 226 ++++++++++++++++++++++
 tb/tb_fuzz_vec_harness.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fuzz_vec_harness.sv
// fuzz_vec_harness
//   Stimulus/response harness for a fuzzed DUT. On start it drives NUM_VEC
//   generated vectors into the DUT (one per clock), folds every DUT response
//   into a 32-bit MISR signature and reports done plus pass/fail against a
//   golden signature.
//
// Parameters
//   IN_W     DUT input bus width (>= 32)
//   OUT_W    DUT output bus width (>= 1)
//   NUM_VEC  vectors per run (1..65535)
//   DUT_LAT  DUT latency from stim to resp in clocks (0..15)
//
// Ports
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   start, abort        begin a run (IDLE only) / synchronous cancel
//   mode, seed, preload generator setup, captured at start
//   golden              expected signature, compared when the run ends
//   resp                DUT output bus
//   stim, stim_valid    registered DUT input vector and its live flag
//   busy, done          run in progress / one-cycle end-of-run pulse
//   sig, pass           MISR value / registered signature match
module fuzz_vec_harness #(
  parameter int IN_W    = 79,
  parameter int OUT_W   = 646,
  parameter int NUM_VEC = 21,
  parameter int DUT_LAT = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [1:0]       mode,
  input  logic [31:0]      seed,
  input  logic [IN_W-1:0]  preload,
  input  logic [31:0]      golden,
  input  logic [OUT_W-1:0] resp,
  output logic [IN_W-1:0]  stim,
  output logic             stim_valid,
  output logic             busy,
  output logic             done,
  output logic [31:0]      sig,
  output logic             pass
);

  localparam int          NCH        = (OUT_W + 31) / 32;
  localparam logic [15:0] NV         = 16'(NUM_VEC);
  localparam logic [31:0] LFSR_TAPS  = 32'h80200003;
  localparam logic [31:0] MISR_POLY  = 32'h04C11DB7;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  function automatic logic [31:0] lfsr_step(input logic [31:0] l);
    return (l >> 1) ^ (l[0] ? LFSR_TAPS : 32'h0);
  endfunction

  // XOR of all 32-bit chunks of the response, top chunk zero-padded.
  function automatic logic [31:0] fold_resp(input logic [OUT_W-1:0] r);
    logic [NCH*32-1:0] pad;
    logic [31:0]       acc;
    pad            = '0;
    pad[OUT_W-1:0] = r;
    acc            = '0;
    for (int i = 0; i < NCH; i++) acc ^= pad[i*32 +: 32];
    return acc;
  endfunction

  function automatic logic [31:0] misr_step(input logic [31:0] m, input logic [31:0] f);
    return {m[30:0], 1'b0} ^ (m[31] ? MISR_POLY : 32'h0) ^ f;
  endfunction

  // Successor of the current vector. Walking-one is a rotate, so it wraps
  // back to bit 0 after IN_W vectors; modes 0 and 3 shift in the LFSR word.
  function automatic logic [IN_W-1:0] next_vec(input logic [1:0]      m,
                                               input logic [IN_W-1:0] cur,
                                               input logic [31:0]     l,
                                               input logic [IN_W-1:0] pl);
    case (m)
      2'd1:    next_vec = {cur[IN_W-2:0], cur[IN_W-1]};
      2'd2:    next_vec = pl;
      default: next_vec = (cur << 32) | IN_W'(l);
    endcase
  endfunction

  state_t            state_q, state_d;
  logic [1:0]        mode_q, mode_d;
  logic [IN_W-1:0]   preload_q, preload_d;
  logic [IN_W-1:0]   stim_q, stim_d;
  logic [31:0]       lfsr_q, lfsr_d;
  logic [31:0]       misr_q, misr_d;
  logic              stim_valid_q, stim_valid_d;
  logic              pass_q, pass_d;
  logic [15:0]       vec_cnt_q, vec_cnt_d;
  logic [15:0]       cap_cnt_q, cap_cnt_d;
  logic              start_go;
  logic              cap_valid;
  logic [31:0]       seed_eff;
  logic [IN_W-1:0]   vec0;

  // abort beats a simultaneous start in IDLE
  assign start_go = (state_q == S_IDLE) && start && !abort;
  // an all-zero LFSR would lock up
  assign seed_eff = (seed == 32'h0) ? 32'h1 : seed;

  always_comb begin
    case (mode)
      2'd1:    vec0 = {{(IN_W-1){1'b0}}, 1'b1};
      2'd2:    vec0 = preload;
      default: vec0 = IN_W'(seed_eff);
    endcase
  end

  // cap_valid is stim_valid delayed to line up with the DUT response.
  generate
    if (DUT_LAT == 0) begin : g_no_dly
      assign cap_valid = stim_valid_q;
    end else begin : g_dly
      logic [DUT_LAT-1:0] dly_q, dly_d;
      always_comb begin
        dly_d = (dly_q << 1) | DUT_LAT'(stim_valid_q);
        if (abort || start_go) dly_d = '0;
      end
      always_ff @(posedge clk or posedge rst) begin
        if (rst) dly_q <= '0;
        else     dly_q <= dly_d;
      end
      assign cap_valid = dly_q[DUT_LAT-1];
    end
  endgenerate

  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    preload_d    = preload_q;
    lfsr_d       = lfsr_q;
    stim_d       = stim_q;
    stim_valid_d = stim_valid_q;
    vec_cnt_d    = vec_cnt_q;
    cap_cnt_d    = cap_cnt_q;
    misr_d       = misr_q;
    pass_d       = pass_q;

    if (cap_valid) begin
      misr_d    = misr_step(misr_q, fold_resp(resp));
      cap_cnt_d = cap_cnt_q + 16'd1;
    end

    case (state_q)
      S_IDLE: begin
        if (start_go) begin
          state_d      = S_RUN;
          mode_d       = mode;
          preload_d    = preload;
          stim_d       = vec0;
          lfsr_d       = lfsr_step(seed_eff);
          stim_valid_d = 1'b1;
          vec_cnt_d    = 16'd1;
          misr_d       = '0;
          cap_cnt_d    = '0;
          pass_d       = 1'b0;
        end
      end
      S_RUN, S_DRAIN: begin
        // every response folded: the signature is final here
        if (cap_cnt_q == NV) begin
          state_d      = S_DONE;
          stim_valid_d = 1'b0;
          pass_d       = (misr_q == golden);
        end else if (state_q == S_RUN) begin
          if (vec_cnt_q < NV) begin
            stim_d    = next_vec(mode_q, stim_q, lfsr_q, preload_q);
            lfsr_d    = lfsr_step(lfsr_q);
            vec_cnt_d = vec_cnt_q + 16'd1;
          end else begin
            stim_valid_d = 1'b0;
            state_d      = S_DRAIN;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (abort) begin
      state_d      = S_IDLE;
      stim_valid_d = 1'b0;
      pass_d       = 1'b0;
      misr_d       = misr_q;
      cap_cnt_d    = cap_cnt_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      mode_q       <= '0;
      preload_q    <= '0;
      lfsr_q       <= '0;
      stim_q       <= '0;
      stim_valid_q <= 1'b0;
      vec_cnt_q    <= '0;
      cap_cnt_q    <= '0;
      misr_q       <= '0;
      pass_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      preload_q    <= preload_d;
      lfsr_q       <= lfsr_d;
      stim_q       <= stim_d;
      stim_valid_q <= stim_valid_d;
      vec_cnt_q    <= vec_cnt_d;
      cap_cnt_q    <= cap_cnt_d;
      misr_q       <= misr_d;
      pass_q       <= pass_d;
    end
  end

  // misr only moves while a run is live, so sig holds after DONE
  assign stim       = stim_q;
  assign stim_valid = stim_valid_q;
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);
  assign sig        = misr_q;
  assign pass       = pass_q;

endmodule

// File: tb/tb_fuzz_vec_harness.sv
// Bench for fuzz_vec_harness: four harness instances with different
// parameters share clock, reset and setup inputs; each gets its own start.
//   a: NUM_VEC=21, DUT_LAT=0, 646-bit response replicating stim
//   b: NUM_VEC=2,  DUT_LAT=0, 32-bit response driven by the bench
//   c: NUM_VEC=5,  DUT_LAT=3, three-register pipeline of stim
//   d: NUM_VEC=80, DUT_LAT=0, response tied to zero
module tb_fuzz_vec_harness;
  localparam int IW = 79;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, abort;
  logic [1:0]    mode;
  logic [31:0]   seed, golden;
  logic [IW-1:0] preload;
  logic          start_a, start_b, start_c, start_d;
  int            checks = 0;
  int            failures = 0;

  logic [IW-1:0] stim_a, stim_b, stim_c, stim_d;
  logic          sv_a, sv_b, sv_c, sv_d;
  logic          busy_a, busy_b, busy_c, busy_d;
  logic          done_a, done_b, done_c, done_d;
  logic          pass_a, pass_b, pass_c, pass_d;
  logic [31:0]   sig_a, sig_b, sig_c, sig_d;
  logic [645:0]  resp_a;
  logic [31:0]   resp_b;
  logic [IW-1:0] p1, p2, p3;

  always_comb begin
    resp_a = '0;
    for (int i = 0; i < 646; i++) resp_a[i] = stim_a[i % IW];
  end

  always @(posedge clk) begin
    p1 <= stim_c;
    p2 <= p1;
    p3 <= p2;
  end

  fuzz_vec_harness #(.IN_W(IW), .OUT_W(646), .NUM_VEC(21), .DUT_LAT(0)) u_a (
    .clk(clk), .rst(rst), .start(start_a), .abort(abort), .mode(mode), .seed(seed),
    .preload(preload), .golden(golden), .resp(resp_a), .stim(stim_a), .stim_valid(sv_a),
    .busy(busy_a), .done(done_a), .sig(sig_a), .pass(pass_a));

  fuzz_vec_harness #(.IN_W(IW), .OUT_W(32), .NUM_VEC(2), .DUT_LAT(0)) u_b (
    .clk(clk), .rst(rst), .start(start_b), .abort(abort), .mode(mode), .seed(seed),
    .preload(preload), .golden(golden), .resp(resp_b), .stim(stim_b), .stim_valid(sv_b),
    .busy(busy_b), .done(done_b), .sig(sig_b), .pass(pass_b));

  fuzz_vec_harness #(.IN_W(IW), .OUT_W(IW), .NUM_VEC(5), .DUT_LAT(3)) u_c (
    .clk(clk), .rst(rst), .start(start_c), .abort(abort), .mode(mode), .seed(seed),
    .preload(preload), .golden(golden), .resp(p3), .stim(stim_c), .stim_valid(sv_c),
    .busy(busy_c), .done(done_c), .sig(sig_c), .pass(pass_c));

  fuzz_vec_harness #(.IN_W(IW), .OUT_W(32), .NUM_VEC(80), .DUT_LAT(0)) u_d (
    .clk(clk), .rst(rst), .start(start_d), .abort(abort), .mode(mode), .seed(seed),
    .preload(preload), .golden(golden), .resp(32'h0), .stim(stim_d), .stim_valid(sv_d),
    .busy(busy_d), .done(done_d), .sig(sig_d), .pass(pass_d));

  // ---------------- reference model ----------------
  logic [IW-1:0] exp_vec [0:127];

  function automatic logic [31:0] lfsr_next(input logic [31:0] l);
    return (l >> 1) ^ (l[0] ? 32'h80200003 : 32'h0);
  endfunction

  function automatic logic [31:0] misr_next(input logic [31:0] m, input logic [31:0] f);
    return {m[30:0], 1'b0} ^ (m[31] ? 32'h04C11DB7 : 32'h0) ^ f;
  endfunction

  function automatic logic [31:0] fold704(input logic [703:0] x);
    logic [31:0] a;
    a = '0;
    for (int i = 0; i < 22; i++) a ^= x[i*32 +: 32];
    return a;
  endfunction

  function automatic logic [703:0] spread_a(input logic [IW-1:0] v);
    logic [703:0] x;
    x = '0;
    for (int i = 0; i < 646; i++) x[i] = v[i % IW];
    return x;
  endfunction

  task automatic build_vecs(input logic [1:0] m, input logic [31:0] sd,
                            input logic [IW-1:0] pl, input int n);
    logic [31:0]   l;
    logic [IW-1:0] acc, one;
    l = sd; acc = '0; one = '0; one[0] = 1'b1;
    for (int k = 0; k < n; k++) begin
      case (m)
        2'd1: exp_vec[k] = one << (k % IW);
        2'd2: exp_vec[k] = pl;
        default: begin
          acc = (acc << 32) | {47'b0, l};
          exp_vec[k] = acc;
          l = lfsr_next(l);
        end
      endcase
    end
  endtask

  function automatic logic [31:0] model_sig_a(input int n);
    logic [31:0] m;
    m = '0;
    for (int k = 0; k < n; k++) m = misr_next(m, fold704(spread_a(exp_vec[k])));
    return m;
  endfunction

  function automatic logic [31:0] model_sig_c(input int n);
    logic [31:0] m;
    m = '0;
    for (int k = 0; k < n; k++) m = misr_next(m, fold704({625'b0, exp_vec[k]}));
    return m;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    rst = 1'b1; abort = 1'b0; mode = '0; seed = '0; golden = '0; preload = '0;
    start_a = 0; start_b = 0; start_c = 0; start_d = 0; resp_b = '0;
    repeat (3) tick;
    checks++;
    if (stim_a !== '0 || sv_a !== 1'b0) begin
      failures++; $display("FAIL reset_stim got stim=%h valid=%b want 0/0", stim_a, sv_a);
    end
    checks++;
    if ({busy_a, done_a, pass_a} !== 3'b000) begin
      failures++; $display("FAIL reset_ctrl got busy/done/pass=%b want 000", {busy_a, done_a, pass_a});
    end
    checks++;
    if (sig_a !== 32'h0) begin
      failures++; $display("FAIL reset_sig got %h want 0", sig_a);
    end
    rst = 1'b0;
    tick;
  endtask

  task automatic run_a(input logic [1:0] m, input logic [31:0] drv_seed,
                       input logic [31:0] mdl_seed, input logic [IW-1:0] pl, input bit good);
    logic [31:0] es;
    int          n, cyc;
    n = 21;
    build_vecs(m, mdl_seed, pl, n);
    es = model_sig_a(n);
    mode = m; seed = drv_seed; preload = pl; golden = good ? es : ~es;
    start_a = 1'b1;
    tick;
    // setup changes after start must not affect the run
    mode = 2'($urandom); seed = $urandom; preload = {15'($urandom), $urandom, $urandom};
    for (int k = 0; k < n; k++) begin
      checks++;
      if (stim_a !== exp_vec[k] || sv_a !== 1'b1 || busy_a !== 1'b1) begin
        failures++;
        $display("FAIL run_vec k=%0d got stim=%h valid=%b want %h", k, stim_a, sv_a, exp_vec[k]);
      end
      if (k == 1) start_a = 1'b0;  // start held into RUN is ignored
      tick;
    end
    checks++;
    if (sv_a !== 1'b0 || stim_a !== exp_vec[n-1]) begin
      failures++; $display("FAIL run_hold got stim=%h valid=%b want %h/0", stim_a, sv_a, exp_vec[n-1]);
    end
    cyc = 0;
    while (done_a !== 1'b1 && cyc < 10) begin tick; cyc++; end
    checks++;
    if (cyc != 1) begin
      failures++; $display("FAIL run_done_latency got %0d want 1", cyc);
    end
    checks++;
    if (sig_a !== es) begin
      failures++; $display("FAIL run_sig got %h want %h", sig_a, es);
    end
    checks++;
    if (pass_a !== good) begin
      failures++; $display("FAIL run_pass got %b want %b", pass_a, good);
    end
    tick;
    checks++;
    if ({done_a, busy_a, pass_a} !== {1'b0, 1'b0, good} || sig_a !== es) begin
      failures++;
      $display("FAIL run_after got done/busy/pass=%b sig=%h want 00%b %h", {done_a, busy_a, pass_a}, sig_a, good, es);
    end
  endtask

  task automatic test_random_modes;
    for (int i = 0; i < 6; i++) begin
      logic [31:0] s;
      s = $urandom | 32'h1;
      run_a(2'(i % 4), s, s, {15'($urandom), $urandom, $urandom}, 1'($urandom));
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] s;
    s = $urandom | 32'h1;
    run_a(2'd2, s, s, {15'($urandom), $urandom, $urandom}, 1'b1);
    run_a(2'd3, s, s, '0, 1'b1);
  endtask

  task automatic test_seed0;
    run_a(2'd0, 32'h0, 32'h1, '0, 1'b1);
    run_a(2'd3, 32'h0, 32'h1, '0, 1'b0);
  endtask

  task automatic test_plan_b;
    int first, cnt;
    mode = 2'd0; seed = 32'h1; golden = 32'h3; resp_b = 32'h1;
    start_b = 1'b1;
    tick;
    start_b = 1'b0;
    checks++;
    if (stim_b !== 79'h1 || sv_b !== 1'b1) begin
      failures++; $display("FAIL b_vec0 got %h valid=%b want 1", stim_b, sv_b);
    end
    tick;
    checks++;
    if (stim_b !== 79'h0000000180200003 || sv_b !== 1'b1) begin
      failures++; $display("FAIL b_vec1 got %h valid=%b want 180200003", stim_b, sv_b);
    end
    tick;
    checks++;
    if (sv_b !== 1'b0) begin
      failures++; $display("FAIL b_valid_len got %b want 0", sv_b);
    end
    first = -1; cnt = 0;
    for (int i = 1; i <= 6; i++) begin
      tick;
      if (done_b === 1'b1) begin
        cnt++;
        if (first < 0) first = i;
        checks++;
        if (sig_b !== 32'h3 || pass_b !== 1'b1) begin
          failures++; $display("FAIL b_sig got sig=%h pass=%b want 3/1", sig_b, pass_b);
        end
      end
    end
    checks++;
    if (first != 1 || cnt != 1) begin
      failures++; $display("FAIL b_done got first=%0d count=%0d want 1/1", first, cnt);
    end
    checks++;
    if (busy_b !== 1'b0 || pass_b !== 1'b1) begin
      failures++; $display("FAIL b_idle got busy=%b pass=%b want 0/1", busy_b, pass_b);
    end
  endtask

  task automatic test_walk_d;
    int cyc;
    build_vecs(2'd1, 32'h1, '0, 80);
    mode = 2'd1; golden = 32'h0;
    start_d = 1'b1;
    tick;
    start_d = 1'b0;
    for (int k = 0; k < 80; k++) begin
      checks++;
      if (stim_d !== exp_vec[k] || sv_d !== 1'b1) begin
        failures++; $display("FAIL walk_vec k=%0d got %h want %h", k, stim_d, exp_vec[k]);
      end
      if (k == 78) begin
        checks++;
        if (stim_d !== 79'h4000_0000_0000_0000_0000) begin
          failures++; $display("FAIL walk_bit78 got %h", stim_d);
        end
      end
      if (k == 79) begin
        checks++;
        if (stim_d !== 79'h1) begin
          failures++; $display("FAIL walk_wrap got %h want 1", stim_d);
        end
      end
      tick;
    end
    cyc = 0;
    while (done_d !== 1'b1 && cyc < 10) begin tick; cyc++; end
    checks++;
    if (cyc != 1 || sig_d !== 32'h0 || pass_d !== 1'b1) begin
      failures++; $display("FAIL walk_done got cyc=%0d sig=%h pass=%b want 1/0/1", cyc, sig_d, pass_d);
    end
    tick;
    checks++;
    if (busy_d !== 1'b0) begin
      failures++; $display("FAIL walk_idle got busy=%b want 0", busy_d);
    end
  endtask

  task automatic test_latency_c(input logic [31:0] sd);
    logic [31:0] es;
    int          cyc;
    build_vecs(2'd0, sd, '0, 5);
    es = model_sig_c(5);
    mode = 2'd0; seed = sd; golden = es;
    start_c = 1'b1;
    tick;
    start_c = 1'b0;
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (stim_c !== exp_vec[k] || sv_c !== 1'b1) begin
        failures++; $display("FAIL lat_vec k=%0d got %h want %h", k, stim_c, exp_vec[k]);
      end
      tick;
    end
    cyc = 0;
    while (done_c !== 1'b1 && cyc < 20) begin tick; cyc++; end
    checks++;
    if (cyc != 4) begin
      failures++; $display("FAIL lat_done_latency got %0d want 4", cyc);
    end
    checks++;
    if (sig_c !== es || pass_c !== 1'b1) begin
      failures++; $display("FAIL lat_sig got %h pass=%b want %h/1", sig_c, pass_c, es);
    end
    tick;
    checks++;
    if (busy_c !== 1'b0) begin
      failures++; $display("FAIL lat_idle got busy=%b want 0", busy_c);
    end
  endtask

  task automatic test_reset_mid;
    mode = 2'd0; seed = $urandom | 32'h1;
    start_c = 1'b1;
    tick;
    start_c = 1'b0;
    repeat (6) tick;
    checks++;
    if (busy_c !== 1'b1 || sv_c !== 1'b0) begin
      failures++; $display("FAIL rmid_drain got busy=%b valid=%b want 1/0", busy_c, sv_c);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (stim_c !== '0 || {sv_c, busy_c, done_c, pass_c} !== 4'b0000 || sig_c !== 32'h0) begin
      failures++;
      $display("FAIL rmid_async got stim=%h ctl=%b sig=%h want all 0", stim_c, {sv_c, busy_c, done_c, pass_c}, sig_c);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    tick;
    test_latency_c($urandom | 32'h1);
  endtask

  task automatic test_abort;
    int dn;
    logic [31:0] s;
    s = $urandom | 32'h1;
    run_a(2'd0, s, s, '0, 1'b1);
    abort = 1'b1;
    tick;
    abort = 1'b0;
    checks++;
    if (pass_a !== 1'b0 || busy_a !== 1'b0) begin
      failures++; $display("FAIL abort_idle got pass=%b busy=%b want 0/0", pass_a, busy_a);
    end
    mode = 2'd0; seed = $urandom;
    start_a = 1'b1;
    tick;
    start_a = 1'b0;
    repeat (5) tick;
    abort = 1'b1;
    tick;
    abort = 1'b0;
    checks++;
    if ({busy_a, sv_a, pass_a} !== 3'b000) begin
      failures++; $display("FAIL abort_run got busy/valid/pass=%b want 000", {busy_a, sv_a, pass_a});
    end
    dn = 0;
    for (int i = 0; i < 40; i++) begin
      tick;
      if (done_a === 1'b1 || busy_a === 1'b1) dn++;
    end
    checks++;
    if (dn != 0) begin
      failures++; $display("FAIL abort_no_done got %0d active cycles want 0", dn);
    end
    start_a = 1'b1; abort = 1'b1;
    tick;
    start_a = 1'b0; abort = 1'b0;
    tick;
    checks++;
    if (busy_a !== 1'b0 || sv_a !== 1'b0) begin
      failures++; $display("FAIL abort_start got busy=%b valid=%b want 0/0", busy_a, sv_a);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog time limit checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_plan_b();
    test_random_modes();
    test_back_to_back();
    test_seed0();
    test_walk_d();
    test_latency_c($urandom | 32'h1);
    test_abort();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
